mem_port_arbiter: RTL and testbench

- Sequences the single shared memory port of the multicycle core between two requesters: CPU (port 0: fetch, ldr, str) and DMA/debug loader (port 1).
- Round-robin arbitration; one transaction in flight at a time; variable-latency memory via ready handshake.
- Watchdog aborts stalled accesses.
- Sits between the core's address mux / data-memory interface and the unified memory.

---
 rtl/cpu_mem_pkg.sv | 15 +
 rtl/mem_wait_timer.sv | 27 ++
 rtl/mem_port_arbiter.sv | 113 +++++++++++
 tb/tb_mem_port_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the core's memory-port sequencing logic.
package cpu_mem_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_ACCESS = 1'b1
  } arb_state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

  localparam int unsigned DEFAULT_TIMEOUT = 15;
  localparam int unsigned WAIT_CNT_W      = 8;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles an access has waited on the memory; flags when the limit is hit.
module mem_wait_timer
  import cpu_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired_c
);

  logic [WAIT_CNT_W-1:0] count;

  // Saturating wait counter, cleared whenever a new access is granted.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + WAIT_CNT_W'(1);
    end
  end

  assign expired_c = (count == WAIT_CNT_W'(TIMEOUT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin sequencer for the single shared memory port (CPU vs DMA/loader).
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          done0,
  output logic          done1,
  output logic          err0,
  output logic          err1,
  output logic [DW-1:0] rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  arb_state_t state;
  logic       owner;
  logic       last_grant;
  logic       arb_open;
  logic       pick_dma;
  logic       expired;

  // Grant decision: a lone requester wins, a tie goes to whoever did not win last.
  always_comb begin
    arb_open = (state == ARB_IDLE) && !reset;
    pick_dma = req1 && (!req0 || (last_grant == REQ_CPU));
    gnt1     = arb_open && pick_dma;
    gnt0     = arb_open && req0 && !pick_dma;
  end

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk       (clk),
    .reset     (reset),
    .clear     (gnt0 || gnt1),
    .enable    ((state == ARB_ACCESS) && !mem_ready),
    .expired_c (expired)
  );

  // Port sequencing FSM; completion pulses default low every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ARB_IDLE;
      owner      <= REQ_CPU;
      last_grant <= REQ_DMA;
      done0      <= 1'b0;
      done1      <= 1'b0;
      err0       <= 1'b0;
      err1       <= 1'b0;
      rdata      <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      err0  <= 1'b0;
      err1  <= 1'b0;
      rdata <= '0;
      case (state)
        ARB_IDLE: begin
          if (gnt0 || gnt1) begin
            owner      <= gnt1 ? REQ_DMA : REQ_CPU;
            last_grant <= gnt1 ? REQ_DMA : REQ_CPU;
            mem_we     <= gnt1 ? we1 : we0;
            mem_addr   <= gnt1 ? addr1 : addr0;
            mem_wdata  <= gnt1 ? wdata1 : wdata0;
            mem_req    <= 1'b1;
            busy       <= 1'b1;
            state      <= ARB_ACCESS;
          end
        end
        ARB_ACCESS: begin
          // A ready in the limit cycle still counts as a successful access.
          if (mem_ready || expired) begin
            state   <= ARB_IDLE;
            mem_req <= 1'b0;
            busy    <= 1'b0;
            done0   <= (owner == REQ_CPU);
            done1   <= (owner == REQ_DMA);
            err0    <= !mem_ready && (owner == REQ_CPU);
            err1    <= !mem_ready && (owner == REQ_DMA);
            rdata   <= (mem_ready && !mem_we) ? mem_rdata : '0;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int unsigned TO = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, done0, done1, err0, err1;
  logic [31:0] rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic last_dma;  // model: which port won the most recent grant

  mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .err0(err0), .err1(err1), .rdata(rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction: grant, ACCESS cycles, completion pulse.
  // lat = ACCESS cycle index on which mem_ready is raised (> TO means never).
  task automatic do_txn(input logic r0, input logic r1, input logic w0, input logic w1,
                        input logic [31:0] a0, input logic [31:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input int lat, input logic [31:0] rd, input string tag);
    logic        dma, ew, ee;
    logic [31:0] ea, ed, erd;
    int          n_access;
    req0 = r0; req1 = r1; we0 = w0; we1 = w1;
    addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
    mem_ready = 1'b0;
    #1;
    dma = r1 && (!r0 || !last_dma);
    checks++;
    if (gnt0 !== (r0 && !dma) || gnt1 !== dma)
      begin errors++; $display("FAIL %s grant: got gnt1,gnt0=%b%b expected %b%b", tag, gnt1, gnt0, dma, r0 && !dma); end
    ew = dma ? w1 : w0;
    ea = dma ? a1 : a0;
    ed = dma ? d1 : d0;
    last_dma = dma;
    n_access = 0;
    for (int k = 0; k <= int'(TO); k++) begin
      next_cycle();
      req0 = 1'($urandom_range(0, 1));
      req1 = 1'($urandom_range(0, 1));
      mem_ready = (k == lat);
      mem_rdata = (k == lat) ? rd : $urandom;
      #1;
      n_access++;
      checks++;
      if (mem_req !== 1'b1 || busy !== 1'b1 || mem_we !== ew || mem_addr !== ea || mem_wdata !== ed)
        begin errors++; $display("FAIL %s access[%0d]: got req=%b busy=%b we=%b addr=%h wdata=%h expected 1 1 %b %h %h", tag, k, mem_req, busy, mem_we, mem_addr, mem_wdata, ew, ea, ed); end
      checks++;
      if ({gnt0, gnt1, done0, done1} !== 4'b0000)
        begin errors++; $display("FAIL %s quiet[%0d]: got gnt0,gnt1,done0,done1=%b expected 0000", tag, k, {gnt0, gnt1, done0, done1}); end
      if (k == lat) break;
    end
    next_cycle();
    req0 = 1'b0; req1 = 1'b0; mem_ready = 1'b0;
    #1;
    ee  = (lat > int'(TO));
    erd = (ee || ew) ? 32'h0 : rd;
    checks++;
    if (n_access !== (ee ? int'(TO) + 1 : lat + 1))
      begin errors++; $display("FAIL %s access_len: got %0d expected %0d", tag, n_access, ee ? int'(TO) + 1 : lat + 1); end
    checks++;
    if (done0 !== !dma || done1 !== dma || err0 !== (!dma && ee) || err1 !== (dma && ee) || rdata !== erd)
      begin errors++; $display("FAIL %s done: got d0=%b d1=%b e0=%b e1=%b rdata=%h expected %b %b %b %b %h", tag, done0, done1, err0, err1, rdata, !dma, dma, !dma && ee, dma && ee, erd); end
    checks++;
    if (mem_req !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL %s release: got mem_req=%b busy=%b expected 0 0", tag, mem_req, busy); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    next_cycle();
    next_cycle();
    req0 = 1'b1; req1 = 1'b1;
    #1;
    checks++;
    if ({gnt0, gnt1, done0, done1, err0, err1, mem_req, mem_we, busy} !== 9'b0 || rdata !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0)
      begin errors++; $display("FAIL reset_outputs: got ctrl=%b rdata=%h addr=%h wdata=%h expected all zero", {gnt0, gnt1, done0, done1, err0, err1, mem_req, mem_we, busy}, rdata, mem_addr, mem_wdata); end
    next_cycle();
    reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
    last_dma = 1'b1;
  endtask

  task automatic test_tie_alternation();
    for (int i = 0; i < 4; i++)
      do_txn(1'b1, 1'b1, 1'b0, 1'b0, 32'h1000 + 32'(i), 32'h2000 + 32'(i), 32'h0, 32'h0,
             int'($urandom_range(0, 2)), $urandom, "tie");
  endtask

  task automatic test_cpu_read();
    do_txn(1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 32'h0, 0, 32'hDEADBEEF, "cpu_read");
  endtask

  task automatic test_dma_write();
    do_txn(1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h20, 32'h0, 32'h55, 3, 32'hA5A5A5A5, "dma_write");
  endtask

  task automatic test_timeout();
    do_txn(1'b1, 1'b0, 1'b0, 1'b0, 32'h300, 32'h0, 32'h0, 32'h0, 255, 32'h12345678, "timeout");
    do_txn(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h340, 32'h0, 32'h0, 0, 32'h0BADF00D, "after_timeout");
  endtask

  task automatic test_ready_at_timeout();
    do_txn(1'b1, 1'b0, 1'b0, 1'b0, 32'h400, 32'h0, 32'h0, 32'h0, int'(TO), 32'hCAFEF00D, "ready_at_limit");
  endtask

  task automatic test_reset_mid_access();
    req0 = 1'b1; req1 = 1'b0; we0 = 1'b0; addr0 = 32'h500;
    #1;
    checks++;
    if (gnt0 !== 1'b1)
      begin errors++; $display("FAIL rst_mid grant: got gnt0=%b expected 1", gnt0); end
    next_cycle();
    req0 = 1'b0;
    next_cycle();
    reset = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b1)
      begin errors++; $display("FAIL rst_mid pre: got mem_req=%b expected 1", mem_req); end
    next_cycle();
    checks++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || done0 !== 1'b0 || done1 !== 1'b0)
      begin errors++; $display("FAIL rst_mid drop: got mem_req=%b busy=%b done0=%b done1=%b expected 0 0 0 0", mem_req, busy, done0, done1); end
    reset = 1'b0;
    last_dma = 1'b1;
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      checks++;
      if (done0 !== 1'b0 || done1 !== 1'b0 || mem_req !== 1'b0)
        begin errors++; $display("FAIL rst_mid no_done[%0d]: got done0=%b done1=%b mem_req=%b expected 0 0 0", i, done0, done1, mem_req); end
    end
    mem_ready = 1'b0;
    do_txn(1'b1, 1'b1, 1'b0, 1'b0, 32'h600, 32'h700, 32'h0, 32'h0, 1, 32'h600D600D, "rst_mid_tie");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int r, sel, lat, gap;
      r   = int'($urandom_range(1, 3));
      sel = int'($urandom_range(0, 9));
      lat = (sel < 7) ? (sel % 4) : (sel == 7) ? int'(TO) : (sel == 8) ? int'(TO) + 1 : 255;
      do_txn(r[0], r[1], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom, $urandom, $urandom, $urandom, lat, $urandom, "random");
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        next_cycle();
        checks++;
        if ({gnt0, gnt1, done0, done1, err0, err1, mem_req} !== 7'b0 || rdata !== 32'h0)
          begin errors++; $display("FAIL random idle: got ctrl=%b rdata=%h expected zero", {gnt0, gnt1, done0, done1, err0, err1, mem_req}, rdata); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_tie_alternation();
    test_cpu_read();
    test_dma_write();
    test_timeout();
    test_ready_at_timeout();
    test_reset_mid_access();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
